// File: rtl/spike_classifier_pkg.sv
// Shared definitions for the spike classifier: FSM state encoding and a
// constant function used to size the window counter and scan index.
package spike_classifier_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        SCAN,
        DONE
    } state_t;

    // Bits needed to hold 0..value-1; never less than 1 so that
    // WINDOW=1 still yields a legal vector.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 1;
        while ((64'd1 << width) < 64'(value)) begin
            width++;
        end
        return width;
    endfunction

endpackage

// File: rtl/spike_classifier_if.sv
// Handshake/result bundle between the classifier and its controller.
//   start, spike_in          : controller -> classifier
//   layer_clear, busy, done,
//   class_valid, class_out,
//   max_count, no_spike      : classifier -> controller
interface spike_classifier_if #(
    parameter int unsigned NUM_OUTPUTS = 10,
    parameter int unsigned CNT_WIDTH   = 8,
    parameter int unsigned CLASS_WIDTH = 4
);
    logic                   start;
    logic [NUM_OUTPUTS-1:0] spike_in;
    logic                   layer_clear;
    logic                   busy;
    logic                   done;
    logic                   class_valid;
    logic [CLASS_WIDTH-1:0] class_out;
    logic [CNT_WIDTH-1:0]   max_count;
    logic                   no_spike;

    modport master (
        output start, spike_in,
        input  layer_clear, busy, done, class_valid, class_out, max_count, no_spike
    );

    modport slave (
        input  start, spike_in,
        output layer_clear, busy, done, class_valid, class_out, max_count, no_spike
    );
endinterface

// File: rtl/spike_classifier_counter.sv
// spike_counter: one saturating per-neuron spike counter.
//   clk, rst : clock, asynchronous active-low reset
//   clr      : synchronous clear (takes priority over en)
//   en       : count one spike this cycle
//   cnt      : current count, sticks at all-ones
module spike_counter #(
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 en,
    output logic [CNT_WIDTH-1:0] cnt
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spike_classifier.sv
// spike_classifier: counts output-layer spikes over a WINDOW-cycle inference,
// then scans the counters one per cycle for the argmax (ties -> lowest index).
//   clk, rst : clock, asynchronous active-low reset
//   bus      : slave side of spike_classifier_if (start/spike_in in;
//              layer_clear, busy, done, class_valid, class_out,
//              max_count, no_spike out)
module spike_classifier
    import spike_classifier_pkg::*;
#(
    parameter int unsigned NUM_OUTPUTS = 10,
    parameter int unsigned WINDOW      = 100,
    parameter int unsigned CNT_WIDTH   = 8,
    parameter int unsigned CLASS_WIDTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    spike_classifier_if.slave bus
);

    localparam int unsigned WIN_W = clog2(WINDOW);
    localparam int unsigned IDX_W = clog2(NUM_OUTPUTS);

    state_t               state;
    logic [WIN_W-1:0]     window_cnt;
    logic [IDX_W-1:0]     scan_idx;
    logic [IDX_W-1:0]     best_idx;
    logic [CNT_WIDTH-1:0] best_cnt;
    logic [CNT_WIDTH-1:0] cnt [NUM_OUTPUTS];

    logic                 accept;
    logic                 count_en;
    logic [CNT_WIDTH-1:0] scan_cnt;
    logic [IDX_W-1:0]     next_idx;
    logic [CNT_WIDTH-1:0] next_cnt;

    // Gated by rst so the upstream clear never fires while held in reset.
    assign accept          = rst && (state == IDLE) && bus.start;
    assign bus.layer_clear = accept;
    assign count_en        = (state == RUN);

    for (genvar g = 0; g < NUM_OUTPUTS; g++) begin : g_cnt
        spike_counter #(
            .CNT_WIDTH(CNT_WIDTH)
        ) u_counter (
            .clk (clk),
            .rst (rst),
            .clr (accept),
            .en  (count_en && bus.spike_in[g]),
            .cnt (cnt[g])
        );
    end

    // Running argmax including the neuron under scan, so the last scan
    // cycle can publish the final result directly into DONE.
    always_comb begin
        scan_cnt = cnt[scan_idx];
        next_idx = best_idx;
        next_cnt = best_cnt;
        if (scan_cnt > best_cnt) begin
            next_idx = scan_idx;
            next_cnt = scan_cnt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            window_cnt      <= '0;
            scan_idx        <= '0;
            best_idx        <= '0;
            best_cnt        <= '0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.class_valid <= 1'b0;
            bus.class_out   <= '0;
            bus.max_count   <= '0;
            bus.no_spike    <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        window_cnt      <= '0;
                        bus.class_valid <= 1'b0;
                        bus.busy        <= 1'b1;
                        state           <= RUN;
                    end
                end
                RUN: begin
                    window_cnt <= window_cnt + 1'b1;
                    if (window_cnt == WIN_W'(WINDOW - 1)) begin
                        scan_idx <= '0;
                        best_idx <= '0;
                        best_cnt <= '0;
                        state    <= SCAN;
                    end
                end
                SCAN: begin
                    best_idx <= next_idx;
                    best_cnt <= next_cnt;
                    scan_idx <= scan_idx + 1'b1;
                    if (scan_idx == IDX_W'(NUM_OUTPUTS - 1)) begin
                        bus.class_out   <= CLASS_WIDTH'(next_idx);
                        bus.max_count   <= next_cnt;
                        bus.no_spike    <= (next_cnt == '0);
                        bus.class_valid <= 1'b1;
                        bus.done        <= 1'b1;
                        state           <= DONE;
                    end
                end
                DONE: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spike_classifier.sv
// Bench for spike_classifier: two instances (A: 4 outputs, window 8, 4-bit
// counters; B: 4 outputs, window 20, 3-bit counters) checked every cycle
// against a timeline model, plus literal expectations per scenario.
module tb_spike_classifier;

    localparam int N      = 4;
    localparam int WIN_A  = 8;
    localparam int WIN_B  = 20;
    localparam int CW_A   = 4;
    localparam int CW_B   = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    spike_classifier_if #(.NUM_OUTPUTS(N), .CNT_WIDTH(CW_A), .CLASS_WIDTH(2)) ia ();
    spike_classifier_if #(.NUM_OUTPUTS(N), .CNT_WIDTH(CW_B), .CLASS_WIDTH(2)) ib ();

    spike_classifier #(.NUM_OUTPUTS(N), .WINDOW(WIN_A), .CNT_WIDTH(CW_A), .CLASS_WIDTH(2))
        dut_a (.clk(clk), .rst(rst), .bus(ia));
    spike_classifier #(.NUM_OUTPUTS(N), .WINDOW(WIN_B), .CNT_WIDTH(CW_B), .CLASS_WIDTH(2))
        dut_b (.clk(clk), .rst(rst), .bus(ib));

    int n_vec = 0;
    int n_err = 0;

    // Actual outputs gathered per instance
    logic [1:0] a_busy, a_done, a_valid, a_lc, a_nos, a_start;
    logic [1:0] a_cls [2];
    logic [3:0] a_max [2];
    logic [N-1:0] a_spk [2];
    assign a_busy  = {ib.busy, ia.busy};
    assign a_done  = {ib.done, ia.done};
    assign a_valid = {ib.class_valid, ia.class_valid};
    assign a_lc    = {ib.layer_clear, ia.layer_clear};
    assign a_nos   = {ib.no_spike, ia.no_spike};
    assign a_start = {ib.start, ia.start};
    assign a_cls[0] = ia.class_out;
    assign a_cls[1] = ib.class_out;
    assign a_max[0] = ia.max_count;
    assign a_max[1] = {1'b0, ib.max_count};
    assign a_spk[0] = ia.spike_in;
    assign a_spk[1] = ib.spike_in;

    task automatic chk(input string name, input int d, input logic [31:0] act, input int exp);
        n_vec++;
        if (act !== 32'(exp)) begin
            n_err++;
            $display("FAIL %s dut%0d: got %0d expected %0d", name, d, act, exp);
        end
    endtask

    // Timeline model: age = cycles since acceptance; sampling covers ages
    // 0..win-1, the result appears at age win+N, busy spans ages 0..win+N.
    int win  [2] = '{WIN_A, WIN_B};
    int cmax [2] = '{15, 7};
    bit m_active [2];
    int m_age    [2];
    int m_cnt    [2][N];
    int m_cls    [2];
    int m_max    [2];
    int m_nos    [2];
    int m_valid  [2];
    int n_done_act [2];
    int n_lc_act   [2];

    initial begin
        for (int d = 0; d < 2; d++) begin
            m_active[d] = 0; m_age[d] = 0; m_cls[d] = 0; m_max[d] = 0;
            m_nos[d] = 0; m_valid[d] = 0; n_done_act[d] = 0; n_lc_act[d] = 0;
            for (int k = 0; k < N; k++) m_cnt[d][k] = 0;
        end
    end

    always @(posedge clk or negedge rst) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst) begin
                m_active[d] = 0; m_age[d] = 0; m_cls[d] = 0; m_max[d] = 0;
                m_nos[d] = 0; m_valid[d] = 0;
                for (int k = 0; k < N; k++) m_cnt[d][k] = 0;
            end else if (!m_active[d]) begin
                if (a_start[d]) begin
                    m_active[d] = 1; m_age[d] = 0; m_valid[d] = 0;
                    for (int k = 0; k < N; k++) m_cnt[d][k] = 0;
                end
            end else begin
                if (m_age[d] < win[d])
                    for (int k = 0; k < N; k++)
                        if (a_spk[d][k] && m_cnt[d][k] < cmax[d]) m_cnt[d][k]++;
                if (m_age[d] == win[d] + N - 1) begin
                    int best;
                    best = 0;
                    for (int k = 1; k < N; k++)
                        if (m_cnt[d][k] > m_cnt[d][best]) best = k;
                    m_cls[d] = best;
                    m_max[d] = m_cnt[d][best];
                    m_nos[d] = (m_cnt[d][best] == 0) ? 1 : 0;
                    m_valid[d] = 1;
                end
                m_age[d]++;
                if (m_age[d] > win[d] + N) m_active[d] = 0;
            end
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            chk("busy", d, 32'(a_busy[d]), m_active[d] ? 1 : 0);
            chk("done", d, 32'(a_done[d]), (m_active[d] && m_age[d] == win[d] + N) ? 1 : 0);
            chk("layer_clear", d, 32'(a_lc[d]), (rst && !m_active[d] && a_start[d]) ? 1 : 0);
            chk("class_valid", d, 32'(a_valid[d]), m_valid[d]);
            chk("class_out", d, 32'(a_cls[d]), m_cls[d]);
            chk("max_count", d, 32'(a_max[d]), m_max[d]);
            chk("no_spike", d, 32'(a_nos[d]), m_nos[d]);
            if (a_done[d] === 1'b1) n_done_act[d]++;
            if (a_lc[d] === 1'b1) n_lc_act[d]++;
        end
    end

    function automatic logic [N-1:0] pattern(input int mode, input int t);
        case (mode)
            1: return (t < 8) ? {1'b0, 1'b1, (t % 2 == 0), 1'b0} : 4'b1111;
            2: return (t < 5) ? 4'b1010 : 4'b0000;
            4: return (t < 8) ? ((t < 2) ? 4'b1001 : 4'b1000) : 4'b0000;
            5: return (t < 6) ? 4'b0001 : ((t >= 8) ? 4'b0010 : 4'b0000);
            6: return (t < 6) ? 4'b1001 : 4'b0001;
            7: return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic set_start(input int d, input logic v);
        if (d == 0) ia.start = v; else ib.start = v;
    endtask

    task automatic set_spike(input int d, input logic [N-1:0] v);
        if (d == 0) ia.spike_in = v; else ib.spike_in = v;
    endtask

    // Entered at posedge+1 of the first RUN cycle; returns at posedge+1 of
    // the cycle after DONE. lat counts cycles from acceptance to done.
    task automatic wait_done(input int d, input int mode, output int lat);
        bit got;
        got = 0;
        lat = 0;
        for (int t = 0; t < 80 && !got; t++) begin
            set_spike(d, pattern(mode, t));
            if (mode == 4) set_start(d, (t == 3 || t == 12));
            @(negedge clk);
            if (a_done[d] === 1'b1) begin
                got = 1;
                lat = t + 1;
            end else begin
                @(posedge clk); #1;
            end
        end
        if (!got) begin
            n_vec++;
            n_err++;
            $display("FAIL timeout dut%0d: got no done expected done within 80 cycles", d);
        end
        @(posedge clk); #1;
        if (mode == 4) set_start(d, 1'b0);
        set_spike(d, '0);
    endtask

    task automatic infer(input int d, input int mode, output int lat);
        set_start(d, 1'b1);
        @(posedge clk); #1;
        set_start(d, 1'b0);
        wait_done(d, mode, lat);
    endtask

    task automatic chk_res(input string name, input int d, input int cls, input int mx, input int nos);
        chk({name, "_class"}, d, 32'(a_cls[d]), cls);
        chk({name, "_max"}, d, 32'(a_max[d]), mx);
        chk({name, "_nospike"}, d, 32'(a_nos[d]), nos);
        chk({name, "_valid"}, d, 32'(a_valid[d]), 1);
    endtask

    initial begin
        int lat;
        int lc0;
        int dn0;
        ia.start = 1'b0; ia.spike_in = '0;
        ib.start = 1'b0; ib.spike_in = '0;
        repeat (3) @(posedge clk);
        #1;
        ia.start = 1'b1;
        #1;
        chk("rst_layer_clear", 0, 32'(a_lc[0]), 0);
        chk("rst_busy", 0, 32'(a_busy[0]), 0);
        chk("rst_valid", 1, 32'(a_valid[1]), 0);
        chk("rst_class", 0, 32'(a_cls[0]), 0);
        ia.start = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;

        // Basic classification
        lc0 = n_lc_act[0];
        infer(0, 1, lat);
        chk("basic_latency", 0, 32'(lat), 13);
        chk_res("basic", 0, 2, 8, 0);
        chk("basic_clear_pulses", 0, 32'(n_lc_act[0] - lc0), 1);

        // Tie between neurons 1 and 3
        infer(0, 2, lat);
        chk_res("tie", 0, 1, 5, 0);

        // No activity
        infer(0, 3, lat);
        chk_res("silent", 0, 0, 0, 1);

        // Reset in the middle of RUN, then a clean inference
        set_start(0, 1'b1);
        @(posedge clk); #1;
        set_start(0, 1'b0);
        set_spike(0, pattern(7, 0));
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("midrst_busy", 0, 32'(a_busy[0]), 0);
        chk("midrst_valid", 0, 32'(a_valid[0]), 0);
        chk("midrst_nospike", 0, 32'(a_nos[0]), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        set_spike(0, '0);
        @(posedge clk); #1;
        infer(0, 2, lat);
        chk("after_rst_latency", 0, 32'(lat), 13);
        chk_res("after_rst", 0, 1, 5, 0);

        // start pulses during RUN and DONE are ignored
        dn0 = n_done_act[0];
        infer(0, 4, lat);
        chk_res("ignored_start", 0, 3, 8, 0);
        repeat (3) begin
            @(negedge clk);
            chk("ignored_start_idle", 0, 32'(a_busy[0]), 0);
        end
        chk("ignored_start_dones", 0, 32'(n_done_act[0] - dn0), 1);
        @(posedge clk); #1;

        // start held high: re-accepted on the first IDLE cycle
        set_start(0, 1'b1);
        @(posedge clk); #1;
        wait_done(0, 5, lat);
        chk("held_latency", 0, 32'(lat), 13);
        chk("held_idle_clear", 0, 32'(a_lc[0]), 1);
        chk("held_idle_valid", 0, 32'(a_valid[0]), 1);
        chk("held_idle_busy", 0, 32'(a_busy[0]), 0);
        chk("held_idle_max", 0, 32'(a_max[0]), 6);
        @(posedge clk); #1;
        chk("held_reaccept_busy", 0, 32'(a_busy[0]), 1);
        chk("held_reaccept_valid", 0, 32'(a_valid[0]), 0);
        set_start(0, 1'b0);
        wait_done(0, 2, lat);
        chk("held_second_latency", 0, 32'(lat), 13);
        chk_res("held_second", 0, 1, 5, 0);

        // Saturation on the 3-bit, 20-cycle instance
        infer(1, 6, lat);
        chk("sat_latency", 1, 32'(lat), 25);
        chk_res("sat", 1, 0, 7, 0);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
